hazard_byp_ctrl: RTL and testbench

- Hazard and bypass controller for the in-order pipeline (IM, ID, EX, DM, WB).
- Tracks the destination registers of the instructions in EX and DM.
- Produces the registered bypass selects consumed by the EX-stage source muxes.
- Inserts load-use bubbles, holds the pipe for multi-cycle extended-unit ops, and applies external freeze and branch flush.

---
 rtl/hazard_byp_ctrl_pkg.sv | 39 +++
 rtl/hazard_byp_ctrl_byp_port_decode.sv | 29 ++
 rtl/hazard_byp_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_byp_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_byp_ctrl_pkg.sv
// Shared types and constants for the hazard/bypass controller.
package hazard_byp_ctrl_pkg;

    // Stored register addresses are zero-extended to this width, which
    // leaves room for any ADDR_W up to 8 bits.
    localparam int unsigned DST_W     = 8;
    // Width of the extended-unit occupancy counter (EXT_LAT up to 15).
    localparam int unsigned EXT_CNT_W = 4;

    // Result kinds carried with each instruction.
    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_EXT  = 2'd2;
    localparam logic [1:0] KIND_POP  = 2'd3;

    // One-hot bypass select per source port: {DM, POP, EXT, EX}.
    localparam logic [3:0] BYP_NONE = 4'b0000;
    localparam logic [3:0] BYP_EX   = 4'b0001;
    localparam logic [3:0] BYP_EXT  = 4'b0010;
    localparam logic [3:0] BYP_POP  = 4'b0100;
    localparam logic [3:0] BYP_DM   = 4'b1000;

    // What the controller remembers about the instruction in a stage.
    typedef struct packed {
        logic             valid;
        logic             we;
        logic [DST_W-1:0] dst;
        logic [1:0]       kind;
    } stage_rec_t;

    // A source read depends on a stage when that stage writes the same
    // non-zero register.
    function automatic logic rec_match(input logic re,
                                       input logic [DST_W-1:0] addr,
                                       input stage_rec_t rec);
        return re && rec.valid && rec.we && (addr == rec.dst) && (addr != '0);
    endfunction

endpackage

// File: rtl/hazard_byp_ctrl_byp_port_decode.sv
// Per-port bypass decode: EX record has priority over DM record.
module byp_port_decode
    import hazard_byp_ctrl_pkg::*;
(
    input  logic             re,
    input  logic [DST_W-1:0] addr,
    input  stage_rec_t       ex_rec,
    input  stage_rec_t       dm_rec,
    output logic [3:0]       sel,
    output logic             load_use
);

    // Priority-encode the forwarding source; a LOAD in EX cannot forward.
    always_comb begin
        sel      = BYP_NONE;
        load_use = 1'b0;
        if (rec_match(re, addr, ex_rec)) begin
            case (ex_rec.kind)
                KIND_ALU:  sel = BYP_EX;
                KIND_EXT:  sel = BYP_EXT;
                KIND_POP:  sel = BYP_POP;
                default:   load_use = 1'b1;
            endcase
        end else if (rec_match(re, addr, dm_rec)) begin
            sel = BYP_DM;
        end
    end

endmodule

// File: rtl/hazard_byp_ctrl.sv
// Hazard and bypass controller for the IM/ID/EX/DM/WB pipeline.
module hazard_byp_ctrl
    import hazard_byp_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned EXT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re0_ID,
    input  logic              re1_ID,
    input  logic [ADDR_W-1:0] p0_addr_ID,
    input  logic [ADDR_W-1:0] p1_addr_ID,
    input  logic              we_ID,
    input  logic [ADDR_W-1:0] dst_addr_ID,
    input  logic [1:0]        kind_ID,
    input  logic              flush_ID,
    input  logic              mem_stall,
    output logic              byp0_EX,
    output logic              byp0_ext_EX,
    output logic              byp0_stack_pop,
    output logic              byp0_DM,
    output logic              byp1_EX,
    output logic              byp1_ext_EX,
    output logic              byp1_stack_pop,
    output logic              byp1_DM,
    output logic              stall_IM_ID,
    output logic              stall_ID_EX,
    output logic              stall_EX_DM,
    output logic              bubble_ID_EX,
    output logic              ext_busy
);

    stage_rec_t           ex_rec_q, ex_rec_d;
    stage_rec_t           dm_rec_q, dm_rec_d;
    logic [EXT_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]           byp0_q, byp0_d;
    logic [3:0]           byp1_q, byp1_d;

    logic [DST_W-1:0] p0_addr, p1_addr;
    stage_rec_t       id_rec;
    logic [3:0]       sel0, sel1;
    logic             lu0, lu1;
    logic             busy;
    logic             s_im, s_id, s_ex, bub;

    assign p0_addr = DST_W'(p0_addr_ID);
    assign p1_addr = DST_W'(p1_addr_ID);

    // Record of the instruction currently in ID, as it would enter EX.
    always_comb begin
        id_rec       = '0;
        id_rec.valid = 1'b1;
        id_rec.we    = we_ID;
        id_rec.dst   = DST_W'(dst_addr_ID);
        id_rec.kind  = kind_ID;
    end

    byp_port_decode u_dec0 (
        .re       (re0_ID),
        .addr     (p0_addr),
        .ex_rec   (ex_rec_q),
        .dm_rec   (dm_rec_q),
        .sel      (sel0),
        .load_use (lu0)
    );

    byp_port_decode u_dec1 (
        .re       (re1_ID),
        .addr     (p1_addr),
        .ex_rec   (ex_rec_q),
        .dm_rec   (dm_rec_q),
        .sel      (sel1),
        .load_use (lu1)
    );

    assign busy = (cnt_q != '0);

    // Stall/bubble decisions and next state; mem_stall freezes everything,
    // then an occupied EXT unit, then flush/load-use at ID.
    always_comb begin
        s_im     = 1'b0;
        s_id     = 1'b0;
        s_ex     = 1'b0;
        bub      = 1'b0;
        ex_rec_d = ex_rec_q;
        dm_rec_d = dm_rec_q;
        cnt_d    = cnt_q;
        byp0_d   = byp0_q;
        byp1_d   = byp1_q;
        if (mem_stall) begin
            s_im = 1'b1;
            s_id = 1'b1;
            s_ex = 1'b1;
        end else if (busy) begin
            // EXT op stays in EX; DM drains with bubbles meanwhile.
            s_im     = 1'b1;
            s_id     = 1'b1;
            dm_rec_d = '0;
            cnt_d    = cnt_q - 1'b1;
        end else begin
            // A flushed instruction is dead, so its hazards are ignored.
            s_im     = !flush_ID && (lu0 || lu1);
            bub      = flush_ID || s_im;
            dm_rec_d = ex_rec_q;
            if (bub) begin
                ex_rec_d = '0;
                byp0_d   = BYP_NONE;
                byp1_d   = BYP_NONE;
            end else begin
                ex_rec_d = id_rec;
                byp0_d   = sel0;
                byp1_d   = sel1;
                if (kind_ID == KIND_EXT) begin
                    cnt_d = EXT_CNT_W'(EXT_LAT - 1);
                end
            end
        end
    end

    // Pipeline records, EXT counter and registered bypass selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rec_q <= '0;
            dm_rec_q <= '0;
            cnt_q    <= '0;
            byp0_q   <= BYP_NONE;
            byp1_q   <= BYP_NONE;
        end else begin
            ex_rec_q <= ex_rec_d;
            dm_rec_q <= dm_rec_d;
            cnt_q    <= cnt_d;
            byp0_q   <= byp0_d;
            byp1_q   <= byp1_d;
        end
    end

    // Control outputs are held low while reset is asserted.
    assign stall_IM_ID  = !rst && s_im;
    assign stall_ID_EX  = !rst && s_id;
    assign stall_EX_DM  = !rst && s_ex;
    assign bubble_ID_EX = !rst && bub;
    assign ext_busy     = !rst && busy;

    assign byp0_EX        = byp0_q[0];
    assign byp0_ext_EX    = byp0_q[1];
    assign byp0_stack_pop = byp0_q[2];
    assign byp0_DM        = byp0_q[3];
    assign byp1_EX        = byp1_q[0];
    assign byp1_ext_EX    = byp1_q[1];
    assign byp1_stack_pop = byp1_q[2];
    assign byp1_DM        = byp1_q[3];

endmodule

// File: tb/tb_hazard_byp_ctrl.sv
// Self-checking bench for hazard_byp_ctrl (ADDR_W=5, EXT_LAT=3).
module tb_hazard_byp_ctrl;
    import hazard_byp_ctrl_pkg::*;

    // Control word order: {stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble, ext_busy}
    localparam logic [4:0] C0  = 5'b00000;
    localparam logic [4:0] CLU = 5'b10010;
    localparam logic [4:0] CBZ = 5'b11001;
    localparam logic [4:0] CMS = 5'b11100;
    localparam logic [4:0] CFL = 5'b00010;
    // Byp word order: {p1 DM,POP,EXT,EX, p0 DM,POP,EXT,EX}

    typedef struct packed {
        logic       rst;
        logic       re0;
        logic [4:0] p0;
        logic       re1;
        logic [4:0] p1;
        logic       we;
        logic [4:0] dst;
        logic [1:0] kind;
        logic       flush;
        logic       ms;
        logic [4:0] exp_ctl;
        logic [7:0] exp_byp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       re0_ID = 1'b0, re1_ID = 1'b0, we_ID = 1'b0;
    logic [4:0] p0_addr_ID = '0, p1_addr_ID = '0, dst_addr_ID = '0;
    logic [1:0] kind_ID = '0;
    logic       flush_ID = 1'b0, mem_stall = 1'b0;
    logic       byp0_EX, byp0_ext_EX, byp0_stack_pop, byp0_DM;
    logic       byp1_EX, byp1_ext_EX, byp1_stack_pop, byp1_DM;
    logic       stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX, ext_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    vec_t tbl[$];

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    hazard_byp_ctrl #(.ADDR_W(5), .EXT_LAT(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .re0_ID         (re0_ID),
        .re1_ID         (re1_ID),
        .p0_addr_ID     (p0_addr_ID),
        .p1_addr_ID     (p1_addr_ID),
        .we_ID          (we_ID),
        .dst_addr_ID    (dst_addr_ID),
        .kind_ID        (kind_ID),
        .flush_ID       (flush_ID),
        .mem_stall      (mem_stall),
        .byp0_EX        (byp0_EX),
        .byp0_ext_EX    (byp0_ext_EX),
        .byp0_stack_pop (byp0_stack_pop),
        .byp0_DM        (byp0_DM),
        .byp1_EX        (byp1_EX),
        .byp1_ext_EX    (byp1_ext_EX),
        .byp1_stack_pop (byp1_stack_pop),
        .byp1_DM        (byp1_DM),
        .stall_IM_ID    (stall_IM_ID),
        .stall_ID_EX    (stall_ID_EX),
        .stall_EX_DM    (stall_EX_DM),
        .bubble_ID_EX   (bubble_ID_EX),
        .ext_busy       (ext_busy)
    );

    function automatic vec_t mk(input logic r, input logic e0, input logic [4:0] a0,
                                input logic e1, input logic [4:0] a1,
                                input logic w, input logic [4:0] d, input logic [1:0] k,
                                input logic f, input logic m,
                                input logic [4:0] c, input logic [7:0] b);
        vec_t v;
        v.rst = r; v.re0 = e0; v.p0 = a0; v.re1 = e1; v.p1 = a1;
        v.we = w; v.dst = d; v.kind = k; v.flush = f; v.ms = m;
        v.exp_ctl = c; v.exp_byp = b;
        return v;
    endfunction

    function automatic vec_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h00);
    endfunction

    function automatic vec_t rstv();
        return mk(1, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h00);
    endfunction

    // Drive one cycle: check control before the edge, byp after it.
    task automatic step(input vec_t v, input string tag);
        logic [4:0] act_ctl;
        logic [7:0] act_byp;
        logic [7:0] exp_b;
        @(negedge clk);
        rst = v.rst; re0_ID = v.re0; p0_addr_ID = v.p0; re1_ID = v.re1;
        p1_addr_ID = v.p1; we_ID = v.we; dst_addr_ID = v.dst; kind_ID = v.kind;
        flush_ID = v.flush; mem_stall = v.ms;
        #1;
        act_ctl = {stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX, ext_busy};
        n_checks++;
        if (act_ctl !== v.exp_ctl) begin
            n_errors++;
            $display("FAIL %s ctl: got %b want %b", tag, act_ctl, v.exp_ctl);
        end
        exp_q.push_back(v.exp_byp);
        @(posedge clk);
        #1;
        act_byp = {byp1_DM, byp1_stack_pop, byp1_ext_EX, byp1_EX,
                   byp0_DM, byp0_stack_pop, byp0_ext_EX, byp0_EX};
        exp_b = exp_q.pop_front();
        n_checks++;
        if (act_byp !== exp_b) begin
            n_errors++;
            $display("FAIL %s byp: got %h want %h", tag, act_byp, exp_b);
        end
    endtask

    initial begin
        int n_ms;
        // ALU forwarding, load-use, POP, r0, load-use vs. DM on the other port.
        tbl.push_back(rstv());
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, KIND_ALU, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h01));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, KIND_ALU, 0, 0, C0, 8'h80));
        tbl.push_back(nop());
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, KIND_LOAD, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 0, 0, CLU, 8'h00));
        tbl.push_back(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 0, 0, C0, 8'h88));
        tbl.push_back(nop());
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, KIND_POP, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, KIND_ALU, 0, 0, C0, 8'h40));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, KIND_ALU, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h00));
        tbl.push_back(nop());
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, KIND_ALU, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10, KIND_LOAD, 0, 0, C0, 8'h00));
        tbl.push_back(mk(0, 1, 10, 1, 9, 0, 0, KIND_ALU, 0, 0, CLU, 8'h00));
        tbl.push_back(mk(0, 1, 10, 1, 9, 0, 0, KIND_ALU, 0, 0, C0, 8'h08));
        tbl.push_back(nop());
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // EXT hold: byp held, DM bubbled, then ext forward.
        step(rstv(), "ext_rst");
        step(mk(0, 0, 0, 0, 0, 1, 4, KIND_ALU, 0, 0, C0, 8'h00), "ext_alu_r4");
        step(mk(0, 0, 0, 1, 4, 1, 7, KIND_EXT, 0, 0, C0, 8'h10), "ext_issue");
        step(mk(0, 1, 7, 0, 0, 0, 0, KIND_ALU, 0, 0, CBZ, 8'h10), "ext_busy1");
        step(mk(0, 1, 7, 0, 0, 0, 0, KIND_ALU, 0, 0, CBZ, 8'h10), "ext_busy2");
        step(mk(0, 1, 7, 1, 4, 0, 0, KIND_ALU, 0, 0, C0, 8'h02), "ext_fwd");
        step(nop(), "ext_after");

        // mem_stall over a load-use hazard; bubble exactly once afterwards.
        n_ms = $urandom_range(4, 6);
        step(rstv(), "ms_rst");
        step(mk(0, 0, 0, 0, 0, 1, 1, KIND_ALU, 0, 0, C0, 8'h00), "ms_alu_r1");
        step(mk(0, 1, 1, 0, 0, 1, 5, KIND_LOAD, 0, 0, C0, 8'h01), "ms_load");
        for (int i = 0; i < n_ms; i++) begin
            step(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 0, 1, CMS, 8'h01), $sformatf("ms_hold%0d", i));
        end
        step(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 0, 0, CLU, 8'h00), "ms_bubble");
        step(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 0, 0, C0, 8'h88), "ms_redecode");
        step(nop(), "ms_after");

        // Flush coincident with load-use: bubble without stall.
        step(rstv(), "fl_rst");
        step(mk(0, 0, 0, 0, 0, 1, 5, KIND_LOAD, 0, 0, C0, 8'h00), "fl_load");
        step(mk(0, 1, 5, 1, 5, 1, 6, KIND_ALU, 1, 0, CFL, 8'h00), "fl_kill");
        step(mk(0, 0, 0, 1, 5, 0, 0, KIND_ALU, 0, 0, C0, 8'h80), "fl_next");

        // Reset in the middle of an EXT hold clears everything.
        step(rstv(), "rx_rst");
        step(mk(0, 0, 0, 0, 0, 1, 7, KIND_EXT, 0, 0, C0, 8'h00), "rx_ext");
        step(mk(0, 1, 7, 0, 0, 0, 0, KIND_ALU, 0, 0, CBZ, 8'h00), "rx_busy");
        step(mk(1, 1, 7, 0, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h00), "rx_reset");
        step(mk(0, 1, 7, 0, 0, 0, 0, KIND_ALU, 0, 0, C0, 8'h00), "rx_clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
